key_filter: RTL and testbench

Input-side companion to the LED output blocks. It synchronises and debounces `KEY_W` active-low push-buttons and presents clean key events to the rest of the design:
- debounced level
- one-cycle press and release pulses
- long-press and auto-repeat pulses

Typical consumers are LED pattern controllers that step, pause or change speed on key events.

---
 rtl/key_debounce_ch.sv | 139 +++++++++++++
 rtl/key_filter.sv | 36 +++
 tb/tb_key_filter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_ch.sv
// One push-button channel: two-flop synchroniser, debounce FSM, and hold/auto-repeat timing.
// All outputs are registered; pulses are one cycle wide.
module key_debounce_ch #(
  parameter logic [19:0] CNT_MAX    = 20'd999_999,
  parameter logic [25:0] LONG_MAX   = 26'd49_999_999,
  parameter logic [23:0] REPEAT_MAX = 24'd9_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_FLT = 2'd1;
  localparam logic [1:0] DOWN      = 2'd2;
  localparam logic [1:0] REL_FLT   = 2'd3;

  logic        sync1_q, ks_q;
  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [25:0] hold_q, hold_d;
  logic [23:0] rpt_q, rpt_d;
  logic        rpt_en_q, rpt_en_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    rpt_d     = rpt_q;
    rpt_en_d  = rpt_en_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ks_q) begin
          state_d = PRESS_FLT;
          cnt_d   = '0;
        end
      end
      PRESS_FLT: begin
        if (ks_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = DOWN;
          press_d  = 1'b1;
          level_d  = 1'b1;
          hold_d   = '0;
          rpt_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      DOWN: begin
        if (ks_q) begin
          state_d = REL_FLT;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!ks_q) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
    endcase

    // Hold timing runs while held, but is muted on the release edge itself.
    if ((state_q == DOWN || state_q == REL_FLT) && state_d != IDLE) begin
      if (hold_q != LONG_MAX) hold_d = hold_q + 26'd1;
      if (hold_q == LONG_MAX && !rpt_en_q) begin
        long_d   = 1'b1;
        rpt_en_d = 1'b1;
        rpt_d    = '0;
      end else if (rpt_en_q) begin
        if (rpt_q == REPEAT_MAX) begin
          repeat_d = 1'b1;
          rpt_d    = '0;
        end else begin
          rpt_d = rpt_q + 24'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= 1'b1;
      ks_q      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      rpt_q     <= '0;
      rpt_en_q  <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= key_in;
      ks_q      <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      rpt_en_q  <= rpt_en_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_repeat  = repeat_q;

endmodule

// File: rtl/key_filter.sv
// Debounces KEY_W independent active-low push-buttons into clean level,
// press/release, long-press and auto-repeat events.
module key_filter #(
  parameter int          KEY_W      = 4,
  parameter logic [19:0] CNT_MAX    = 20'd999_999,
  parameter logic [25:0] LONG_MAX   = 26'd49_999_999,
  parameter logic [23:0] REPEAT_MAX = 24'd9_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX    (CNT_MAX),
      .LONG_MAX   (LONG_MAX),
      .REPEAT_MAX (REPEAT_MAX)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: per-cycle run-length reference model feeding a scoreboard,
// plus directed event-count expectations checked by the same monitor.
module tb_key_filter;
  localparam int KW    = 4;
  localparam int CNT_I = 4;
  localparam int LNG_I = 20;
  localparam int REP_I = 9;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [KW-1:0] key_in = 4'hF;
  logic [KW-1:0] key_level, key_press, key_release, key_long, key_repeat;

  always #5 sys_clk = ~sys_clk;

  key_filter #(
    .KEY_W      (KW),
    .CNT_MAX    (20'd4),
    .LONG_MAX   (26'd20),
    .REPEAT_MAX (24'd9)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_repeat  (key_repeat)
  );

  typedef struct packed {
    logic [KW-1:0] lv, pr, rl, lg, rp;
  } exp_t;
  typedef struct {
    string nm;
    int    kind;
    int    key;
    int    ex;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   checks = 0, failures = 0;
  int   prs_cnt[KW], rel_cnt[KW], lng_cnt[KW], rpt_cnt[KW];
  int   both_cnt = 0;

  // Reference model: a key changes state once the synchronised input has disagreed
  // with the current level for CNT+2 consecutive edges; hold events follow from
  // the age of the press.
  bit   h1[KW], h2[KW], lvl[KW];
  int   run[KW], tp[KW];
  int   cyc = 0;
  exp_t m_e;
  bit   m_v;
  int   m_age;

  initial begin
    for (int k = 0; k < KW; k++) begin
      h1[k] = 1; h2[k] = 1; lvl[k] = 0; run[k] = 0; tp[k] = 0;
      prs_cnt[k] = 0; rel_cnt[k] = 0; lng_cnt[k] = 0; rpt_cnt[k] = 0;
    end
  end

  always @(posedge sys_clk) begin
    m_e = '0;
    cyc++;
    if (!sys_rst_n) begin
      for (int k = 0; k < KW; k++) begin
        h1[k] = 1; h2[k] = 1; lvl[k] = 0; run[k] = 0;
      end
    end else begin
      for (int k = 0; k < KW; k++) begin
        m_v   = h2[k];
        h2[k] = h1[k];
        h1[k] = key_in[k];
        run[k] = (m_v == lvl[k]) ? run[k] + 1 : 0;
        if (run[k] == CNT_I + 2) begin
          if (!lvl[k]) begin
            m_e.pr[k] = 1'b1;
            tp[k] = cyc;
          end else begin
            m_e.rl[k] = 1'b1;
          end
          lvl[k] = !lvl[k];
          run[k] = 0;
        end
        m_e.lv[k] = lvl[k];
        if (lvl[k]) begin
          m_age = cyc - tp[k];
          if (m_age == LNG_I + 1) m_e.lg[k] = 1'b1;
          else if (m_age > LNG_I + 1 && (m_age - LNG_I - 1) % (REP_I + 1) == 0) m_e.rp[k] = 1'b1;
        end
      end
    end
    exp_q.push_back(m_e);
  end

  function automatic int cnt_of(input int kind, input int k);
    case (kind)
      0:       return prs_cnt[k];
      1:       return rel_cnt[k];
      2:       return lng_cnt[k];
      3:       return rpt_cnt[k];
      4:       return int'(key_level[k]);
      default: return both_cnt;
    endcase
  endfunction

  exp_t mon_x, mon_a;
  req_t mon_r;
  int   mon_v;

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      if (!sys_rst_n) mon_x = '0;
      mon_a = {key_level, key_press, key_release, key_long, key_repeat};
      checks++;
      if (mon_a !== mon_x) begin
        failures++;
        $display("FAIL scoreboard t=%0t lv/pr/rl/lg/rp act=%h exp=%h", $time, mon_a, mon_x);
      end
      if (sys_rst_n) begin
        for (int k = 0; k < KW; k++) begin
          prs_cnt[k] += int'(key_press[k]);
          rel_cnt[k] += int'(key_release[k]);
          lng_cnt[k] += int'(key_long[k]);
          rpt_cnt[k] += int'(key_repeat[k]);
        end
        if (key_press[0] && key_press[3]) both_cnt++;
      end
    end
    while (req_q.size() > 0) begin
      mon_r = req_q.pop_front();
      mon_v = cnt_of(mon_r.kind, mon_r.key);
      checks++;
      if (mon_v != mon_r.ex) begin
        failures++;
        $display("FAIL %s key=%0d act=%0d exp=%0d", mon_r.nm, mon_r.key, mon_v, mon_r.ex);
      end
    end
  end

  task automatic want(input string nm, input int kind, input int key, input int ex);
    req_t r;
    r.nm = nm; r.kind = kind; r.key = key; r.ex = ex;
    req_q.push_back(r);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  int s0, s1, s2;

  initial begin
    tick(3);
    sys_rst_n = 1'b1;
    tick(3);

    // clean press on key0
    s0 = cnt_of(0, 0);
    key_in[0] = 1'b0;
    tick(10);
    want("clean_press", 0, 0, s0 + 1);
    want("clean_level", 4, 0, 1);

    // short low bursts on key1 never qualify
    s0 = cnt_of(0, 1);
    repeat (4) begin
      key_in[1] = 1'b0; tick(3);
      key_in[1] = 1'b1; tick(1);
    end
    tick(4);
    want("bounce_reject", 0, 1, s0);
    key_in[1] = 1'b0;
    tick(10);
    want("bounce_then_hold", 0, 1, s0 + 1);
    key_in[1] = 1'b1;
    tick(12);

    // long press and auto-repeat on key2
    s0 = cnt_of(2, 2); s1 = cnt_of(3, 2); s2 = cnt_of(1, 2);
    key_in[2] = 1'b0;
    tick(60);
    key_in[2] = 1'b1;
    tick(20);
    want("long_once", 2, 2, s0 + 1);
    want("repeat_three", 3, 2, s1 + 3);
    want("long_release", 1, 2, s2 + 1);

    // release glitch on key0 is rejected
    s0 = cnt_of(1, 0);
    key_in[0] = 1'b1; tick(2);
    key_in[0] = 1'b0; tick(10);
    want("rel_glitch_none", 1, 0, s0);
    want("rel_glitch_level", 4, 0, 1);
    key_in[0] = 1'b1;
    tick(12);
    want("rel_final", 1, 0, s0 + 1);
    want("rel_final_level", 4, 0, 0);

    // reset while key3 is held
    key_in[3] = 1'b0;
    tick(10);
    want("pre_reset_level", 4, 3, 1);
    tick(1);
    s0 = cnt_of(0, 3); s1 = cnt_of(1, 3);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    want("reset_async_level", 4, 3, 0);
    tick(2);
    sys_rst_n = 1'b1;
    tick(12);
    want("post_reset_press", 0, 3, s0 + 1);
    want("post_reset_no_rel", 1, 3, s1);
    key_in[3] = 1'b1;
    tick(12);

    // keys 0 and 3 pressed together
    s0 = cnt_of(5, 0);
    key_in = key_in & 4'b0110;
    tick(10);
    want("concurrent_press", 5, 0, s0 + 1);
    key_in = 4'hF;
    tick(12);

    // randomized toggling on all keys
    repeat (40) begin
      for (int k = 0; k < KW; k++)
        if ($urandom_range(0, 1) == 1) key_in[k] = ~key_in[k];
      tick($urandom_range(1, 35));
    end
    key_in = 4'hF;
    tick(30);
    want("final_idle_level", 4, 2, 0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
